// File: rtl/sram_sprite_writer.sv
// sram_sprite_writer: streams one 16-line sprite into async SRAM; readback verify built when SPRITE_WR_VERIFY_EN is defined
module sram_sprite_writer #(
    parameter logic [19:0] BASE_ADDR = 20'h00000,
    parameter int          WE_PULSE  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  sprite_number,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        verify_err,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);
    localparam int CW = (WE_PULSE > 2) ? $clog2(WE_PULSE) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(WE_PULSE - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_DATA, SETUP, PULSE, HOLD, DONE
`ifdef SPRITE_WR_VERIFY_EN
        , RD_SETUP, RD_WAIT, RD_CMP
`endif
    } state_t;

`ifdef SPRITE_WR_VERIFY_EN
    localparam state_t LINE_END = RD_CMP;
`else
    localparam state_t LINE_END = HOLD;
`endif

    state_t         state, state_d;
    logic [4:0]     sprite;
    logic [3:0]     line;
    logic [19:0]    addr;
    logic [15:0]    data;
    logic [CW-1:0]  cnt;
    logic           last_line;

    assign last_line = line == 4'hF;

    // state register; reset forces IDLE so every strobe drops on the next edge
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end

    // next-state: one line per pass, cnt times the WE pulse and the read wait
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = start ? WAIT_DATA : IDLE;
            WAIT_DATA: state_d = wr_valid ? SETUP : WAIT_DATA;
            SETUP:     state_d = PULSE;
            PULSE:     state_d = (cnt == PULSE_LAST) ? HOLD : PULSE;
`ifdef SPRITE_WR_VERIFY_EN
            HOLD:      state_d = RD_SETUP;
            RD_SETUP:  state_d = RD_WAIT;
            RD_WAIT:   state_d = (cnt == CW'(1)) ? RD_CMP : RD_WAIT;
            RD_CMP:    state_d = last_line ? DONE : WAIT_DATA;
`else
            HOLD:      state_d = last_line ? DONE : WAIT_DATA;
`endif
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // datapath: latch sprite on start, word and its address on accept, advance line at end of each line
    always_ff @(posedge clock) begin
        if (reset) begin
            sprite <= '0;
            line   <= '0;
            addr   <= '0;
            data   <= '0;
            cnt    <= '0;
        end else begin
            cnt <= (state_d == state) ? cnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                sprite <= sprite_number;
                line   <= '0;
            end
            if (state == WAIT_DATA && wr_valid) begin
                data <= wr_data;
                addr <= BASE_ADDR + {11'd0, sprite, line};
            end
            if (state == LINE_END && !last_line) line <= line + 1'b1;
        end
    end

`ifdef SPRITE_WR_VERIFY_EN
    // sticky readback mismatch, cleared only by reset or an accepted start
    always_ff @(posedge clock) begin
        if (reset) verify_err <= 1'b0;
        else if (state == IDLE && start) verify_err <= 1'b0;
        else if (state == RD_CMP && SRAM_DQ_in != data) verify_err <= 1'b1;
    end
    assign SRAM_OE_N = !(state == RD_SETUP || state == RD_WAIT || state == RD_CMP);
`else
    logic unused_dq;
    assign unused_dq  = ^SRAM_DQ_in;
    assign verify_err = 1'b0;
    assign SRAM_OE_N  = 1'b1;
`endif

    assign wr_ready    = state == WAIT_DATA;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign SRAM_ADDR   = addr;
    assign SRAM_DQ_out = data;
    assign SRAM_DQ_oe  = state == SETUP || state == PULSE || state == HOLD;
    assign SRAM_WE_N   = state != PULSE;
    assign SRAM_CE_N   = !(SRAM_DQ_oe || !SRAM_OE_N);
    assign SRAM_LB_N   = SRAM_CE_N;
    assign SRAM_UB_N   = SRAM_CE_N;
endmodule

// File: tb/tb_sram_sprite_writer.sv
// tb_sram_sprite_writer: directed sprite loads with a write/done scoreboard checked by a bus monitor
module tb_sram_sprite_writer;
`ifdef SPRITE_WR_VERIFY_EN
    localparam int LINE_CYC = 9;
`else
    localparam int LINE_CYC = 5;
`endif

    logic clock = 0, reset = 1, start_a = 0, start_b = 0, wr_valid = 0, sel = 0, flip = 0;
    logic [4:0]  sprite_number = 0;
    logic [15:0] wr_data = 0;
    logic        ready_a, busy_a, done_a, verr_a, oe_a, ce_a, oen_a, we_a, lb_a, ub_a;
    logic        ready_b, busy_b, done_b, verr_b, oe_b, ce_b, oen_b, we_b, lb_b, ub_b;
    logic [19:0] addr_a, addr_b;
    logic [15:0] dq_a, dq_b, dq_in_a;
    logic [15:0] mem [0:255];

    int cyc = 0, n_total = 0, n_pass = 0;
    logic [35:0] exp_q[$];
    int          exp_done_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sram_sprite_writer dut_a (
        .clock(clock), .reset(reset), .start(start_a), .sprite_number(sprite_number),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(ready_a), .busy(busy_a),
        .done(done_a), .verify_err(verr_a), .SRAM_ADDR(addr_a), .SRAM_DQ_out(dq_a),
        .SRAM_DQ_oe(oe_a), .SRAM_DQ_in(dq_in_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oen_a),
        .SRAM_WE_N(we_a), .SRAM_LB_N(lb_a), .SRAM_UB_N(ub_a)
    );

    sram_sprite_writer #(.BASE_ADDR(20'hFFE80)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .sprite_number(sprite_number),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(ready_b), .busy(busy_b),
        .done(done_b), .verify_err(verr_b), .SRAM_ADDR(addr_b), .SRAM_DQ_out(dq_b),
        .SRAM_DQ_oe(oe_b), .SRAM_DQ_in(16'h0000), .SRAM_CE_N(ce_b), .SRAM_OE_N(oen_b),
        .SRAM_WE_N(we_b), .SRAM_LB_N(lb_b), .SRAM_UB_N(ub_b)
    );

    // SRAM model for dut_a; flip corrupts bit 0 of line 5 on readback
    always @(posedge clock) if (!we_a && !ce_a) mem[addr_a[7:0]] <= dq_a;
    assign dq_in_a = mem[addr_a[7:0]] ^ {15'd0, flip && addr_a[3:0] == 4'd5};

    logic [19:0] m_addr;
    logic [15:0] m_dq;
    logic m_oe, m_ce, m_we, m_lb, m_ub, m_ready, m_done, m_busy;
    assign m_addr  = sel ? addr_b : addr_a;
    assign m_dq    = sel ? dq_b : dq_a;
    assign m_oe    = sel ? oe_b : oe_a;
    assign m_ce    = sel ? ce_b : ce_a;
    assign m_we    = sel ? we_b : we_a;
    assign m_lb    = sel ? lb_b : lb_a;
    assign m_ub    = sel ? ub_b : ub_a;
    assign m_ready = sel ? ready_b : ready_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_busy  = sel ? busy_b : busy_a;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // monitor: checks every write cycle and done pulse against the scoreboard
    logic        p_we = 1, p_ce = 1, p_oe = 0;
    logic [19:0] p_addr = 0, h_addr = 0;
    logic [15:0] p_dq = 0, h_dq = 0;
    int          lowcnt = 0;
    always @(negedge clock) begin
        if (reset) lowcnt = 0;
        else begin
            if (p_we && !m_we) begin
                chk("setup", {p_ce, p_oe, p_addr == m_addr, p_dq == m_dq}, 4'b0111);
                lowcnt = 1;
                h_addr = m_addr;
                h_dq   = m_dq;
            end else if (m_we === 1'b0) begin
                lowcnt++;
                chk("pulse_stable", {m_ce, m_oe, m_addr == h_addr, m_dq == h_dq}, 4'b0111);
            end else if (!p_we && m_we) begin
                chk("hold", {m_ce, m_lb, m_ub, m_oe, m_addr == h_addr, m_dq == h_dq}, 6'b000111);
                chk("we_width", lowcnt, 2);
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", h_addr, e[35:16]);
                    chk("wr_data", h_dq, e[15:0]);
                end
            end
            if (m_ready === 1'b1) chk("wait_idle", {m_ce, m_we, m_oe}, 3'b110);
            if (m_done === 1'b1) begin
                if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
        p_we = m_we; p_ce = m_ce; p_oe = m_oe; p_addr = m_addr; p_dq = m_dq;
    end

    task automatic send(input logic [15:0] d);
        int n = 0;
        wr_data  = d;
        wr_valid = 1;
        @(negedge clock);
        while (m_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("ready_seen", n < 100, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (m_done !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", n < 400, 1);
        @(posedge clock);
        #1;
        wr_valid = 0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic run_sprite(input logic b, input logic [4:0] spr, input logic [19:0] a0,
                              input logic [15:0] d0, input int stall);
        int c0;
        sprite_number = spr;
        if (b) start_b = 1; else start_a = 1;
        @(posedge clock);
        #1;
        c0 = cyc;
        start_a = 0;
        start_b = 0;
        exp_done_q.push_back(c0 + 16 * LINE_CYC + (stall >= 0 ? 3 : 0));
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({a0 + 20'(i), d0 + 16'(i)});
            if (i == stall) begin
                int n = 0;
                wr_valid = 0;
                while (m_ready !== 1'b1 && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                repeat (3) @(posedge clock);
                #1;
            end
            if (b && i == 2) begin
                start_b = 1;
                sprite_number = 5'd5;
                @(posedge clock);
                #1;
                start_b = 0;
                sprite_number = spr;
            end
            send(d0 + 16'(i));
        end
        wait_done();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wr_ready", ready_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_verify_err", verr_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_dq_out", dq_a, 0);
        chk("rst_dq_oe", oe_a, 0);
        chk("rst_ce_n", ce_a, 1);
        chk("rst_oe_n", oen_a, 1);
        chk("rst_we_n", we_a, 1);
        chk("rst_lb_n", lb_a, 1);
        chk("rst_ub_n", ub_a, 1);
        reset = 0;
        repeat (2) @(posedge clock);
        #1;

        sel = 0;
        run_sprite(0, 5'd3, 20'h00030, 16'hA000, -1);
        run_sprite(0, 5'd3, 20'h00030, 16'h5A00, 7);

        sel = 1;
        run_sprite(1, 5'd31, 20'h00070, 16'h3C00, -1);

        sel = 0;
        sprite_number = 5'd9;
        start_a = 1;
        @(posedge clock);
        #1;
        start_a = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({20'h00090 + 20'(i), 16'hC000 + 16'(i)});
            send(16'hC000 + 16'(i));
        end
        begin
            int n = 0;
            wr_data = 16'hC004;
            wr_valid = 1;
            while (!(m_we === 1'b0 && m_addr == 20'h00094) && n < 100) begin
                @(negedge clock);
                n++;
            end
            chk("line4_pulse_seen", n < 100, 1);
        end
        reset = 1;
        @(posedge clock);
        #1;
        chk("midrst_we_n", m_we, 1);
        chk("midrst_ce_n", m_ce, 1);
        chk("midrst_busy", m_busy, 0);
        wr_valid = 0;
        @(posedge clock);
        #1;
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        run_sprite(0, 5'd9, 20'h00090, 16'hD000, -1);

`ifdef SPRITE_WR_VERIFY_EN
        flip = 1;
        run_sprite(0, 5'd2, 20'h00020, 16'hE000, -1);
        chk("verify_err_set", verr_a, 1);
        flip = 0;
        run_sprite(0, 5'd2, 20'h00020, 16'hE100, -1);
        chk("verify_err_cleared", verr_a, 0);
`endif

        chk("writes_left", exp_q.size(), 0);
        chk("dones_left", exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
